// File: rtl/usb_rx_frontend_if.sv
// Pin and decoded-output bundle for the USB receive front end.
// The pin driver owns dp/dm; the front end owns everything it reports.
interface usb_rx_frontend_if;
  logic       dp_i;
  logic       dm_i;
  logic [1:0] line_state_o;
  logic       bit_strobe_o;
  logic [1:0] rx_state_o;
  logic       eop_o;
  logic       bus_reset_o;

  modport master (
    output dp_i, dm_i,
    input  line_state_o, bit_strobe_o, rx_state_o, eop_o, bus_reset_o
  );

  modport slave (
    input  dp_i, dm_i,
    output line_state_o, bit_strobe_o, rx_state_o, eop_o, bus_reset_o
  );
endinterface

// File: rtl/usb_rx_frontend.sv
// USB receive front end: pin synchroniser, glitch filter, 4-phase DPLL,
// end-of-packet and bus-reset detection. clk_i runs at 4x the bit rate.
module usb_rx_frontend #(
  parameter bit          USB_FULL_SPEED = 1'b1,
  parameter int unsigned RESET_CYCLES   = 120
) (
  input  logic              clk_i,
  input  logic              rst_i,
  usb_rx_frontend_if.slave  bus
);

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_t;

  localparam int unsigned     CW     = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0]   RC_MAX = CW'(RESET_CYCLES);

  line_t          dec;
  line_t          s1_q, s2_q, s3_q;
  line_t          filt_q, filt_d;
  line_t          rx_q, rx_d;
  logic [1:0]     phase_q, phase_d;
  logic           strobe_q, strobe_d;
  logic           eop_q, eop_d;
  logic           se0_seen_q, se0_seen_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bus_reset_q, bus_reset_d;
  logic           line_edge;

  // J/K pin polarity swaps between full and low speed.
  always_comb begin
    dec = LS_SE1;
    unique case ({bus.dp_i, bus.dm_i})
      2'b00:   dec = LS_SE0;
      2'b10:   dec = USB_FULL_SPEED ? LS_J : LS_K;
      2'b01:   dec = USB_FULL_SPEED ? LS_K : LS_J;
      default: dec = LS_SE1;
    endcase
  end

  always_comb begin
    filt_d     = (s2_q == s3_q) ? s2_q : filt_q;
    line_edge  = (filt_d != filt_q);
    phase_d    = line_edge ? '0 : phase_q + 2'd1;
    strobe_d   = (phase_d == 2'd2);
    rx_d       = strobe_d ? filt_d : rx_q;
    eop_d      = strobe_d && (filt_d == LS_J) && se0_seen_q;
    se0_seen_d = strobe_d ? (filt_d == LS_SE0) : se0_seen_q;

    if (filt_d != LS_SE0)
      cnt_d = '0;
    else if (cnt_q == RC_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CW'(1);
    bus_reset_d = (cnt_d == RC_MAX);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q        <= LS_J;
      s2_q        <= LS_J;
      s3_q        <= LS_J;
      filt_q      <= LS_J;
      phase_q     <= '0;
      strobe_q    <= 1'b0;
      rx_q        <= LS_J;
      eop_q       <= 1'b0;
      se0_seen_q  <= 1'b0;
      cnt_q       <= '0;
      bus_reset_q <= 1'b0;
    end else begin
      s1_q        <= dec;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      filt_q      <= filt_d;
      phase_q     <= phase_d;
      strobe_q    <= strobe_d;
      rx_q        <= rx_d;
      eop_q       <= eop_d;
      se0_seen_q  <= se0_seen_d;
      cnt_q       <= cnt_d;
      bus_reset_q <= bus_reset_d;
    end
  end

  assign bus.line_state_o = filt_q;
  assign bus.bit_strobe_o = strobe_q;
  assign bus.rx_state_o   = rx_q;
  assign bus.eop_o        = eop_q;
  assign bus.bus_reset_o  = bus_reset_q;

endmodule
